fphv_pack_cvt: RTL
==================

// Module: fphv_pack_cvt
// PURPOSE
//  Pipelined FP16 <-> binary32 converter for the half-vector FPU path.
//  Packs two binary32 values into one 32-bit word holding two FP16 lanes.
//  Unpacks one FP16 lane of a packed word back to binary32.
//  Fixed 3-cycle latency. A valid bit travels with the data. A global hold stalls the pipeline.
// PARAMETERS
//  (none; all widths are fixed by the FP16 and binary32 formats)
// PORTS
//  clock     in   1   system clock; all state updates on posedge
//  reset     in   1   asynchronous, active-high reset
//  iValid    in   1   input operation valid this cycle
//  iHold     in   1   pipeline stall; when 1, every stage register holds its value
//  iOp       in   2   00=pack, 01=unpack lo lane, 10=unpack hi lane, 11=reserved
//  iValRs    in   32  pack: lo-lane source (binary32); unpack: packed FP16 pair
//  iValRt    in   32  pack: hi-lane source (binary32); unused for unpack
//  oValid    out  1   result valid
//  oValRn    out  32  result word
// BEHAVIOUR
//  - Reset: oValid=0, oValRn=0, all stage valid bits and data cleared.
//    Async assert aborts in-flight ops; no partial result ever appears.
//  - Stages:
//    S1: field split, exponent rebias, range classify.
//    S2: round, carry into exponent, overflow recheck.
//    S3: output register.
//  - Latency 3 cycles: an op with iValid=1 at edge N gives oValid=1 at edge N+3 if no hold.
//  - iHold=1: all stage regs, including oValid/oValRn, keep their values.
//    iValid and operands are ignored that cycle.
//    Back-to-back ops are accepted every non-held cycle.
//  - Bubbles (iValid=0) propagate; oValRn is don't-care, but the RTL drives 0 when oValid=0.
//  - Pack, per lane, with binary32 fields s, e[7:0], f[22:0]; he = e - 112 (signed, 9 bit):
//    e==255, f==0  -> {s,5'h1F,10'h000} (Inf)
//    e==255, f!=0  -> {s,5'h1F,10'h200} (quiet NaN)
//    he>=31        -> {s,5'h1F,10'h000} (overflow to Inf)
//    he<=0         -> {s,15'h0} (flush to signed zero; no FP16 denormals)
//    otherwise     -> {s,he[4:0],f[22:13]}, then rounded (see CONFIGURATION)
//    Rounding carry: on mantissa carry-out, exponent+1; he reaching 31 gives Inf.
//  - Pack output: oValRn = {laneRt[15:0], laneRs[15:0]}.
//  - Unpack: selected lane h = iValRs[15:0] (op 01) or iValRs[31:16] (op 10);
//    fields hs, hx[4:0], hf[9:0]:
//    hx==0   -> {hs,31'h0} (input denormals flushed)
//    hx==31  -> {hs,8'hFF,hf,13'h0} (Inf/NaN preserved)
//    else    -> {hs,hx+8'd112,hf,13'h0}
//  - iOp=11: result 0 with oValid asserted (reserved, no trap).
//  - Sign always passes through, including for zero and Inf results.
// CONFIGURATION
//  FPHV_PACK_RNE_EN defined:
//    pack rounds to nearest-even.
//    g=f[12], st=|f[11:0], l=f[13]; increment mantissa when g&(st|l).
//  FPHV_PACK_RNE_EN undefined:
//    pack truncates (f[12:0] discarded); S2 is a pure pass-through register.
//    Latency stays 3 cycles.
//  Unpack is exact in both configurations.
// TESTING
//  1 pack Rs=3F800000, Rt=C0000000 -> oValRn=C0003C00, oValid exactly 3 clocks later
//  2 pack Rs=3F803000 -> lo=3C02 (RNE); pack Rs=3F801000 -> lo=3C00 (tie to even);
//    without the macro: 3C01 and 3C00
//  3 pack Rs=477FF000 -> lo=7C00 (RNE overflow to Inf) / 7BFF (truncate);
//    Rs=322BCC77 -> 0000; Rs=FFC00000 -> FE00
//  4 unpack op01 Rs=xxxx3C00 -> 3F800000; op10 Rs=FC00xxxx -> FF800000;
//    op01 Rs=xxxx0001 -> 00000000
//  5 stream 6 back-to-back ops, iHold=1 for 2 cycles mid-stream ->
//    results in order, none lost or duplicated, outputs frozen during hold
//  6 assert reset with 3 ops in flight -> oValid=0, oValRn=0 immediately;
//    no stale results after release

Source files
------------

// File: rtl/fphv_pack_cvt.sv
// Three-stage FP16 <-> binary32 pack/unpack converter with valid tracking and global hold.
// Optional macro FPHV_PACK_RNE_EN selects round-to-nearest-even on pack; otherwise pack truncates.
module fphv_pack_cvt (
  input  logic        clock,
  input  logic        reset,
  input  logic        iValid,
  input  logic        iHold,
  input  logic [1:0]  iOp,
  input  logic [31:0] iValRs,
  input  logic [31:0] iValRt,
  output logic        oValid,
  output logic [31:0] oValRn
);

`ifdef FPHV_PACK_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_PACK   = 2'b00,
    OP_UNP_LO = 2'b01,
    OP_UNP_HI = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  // Returns {round_increment, prelim_half}; the increment is applied in S2 so a
  // mantissa carry ripples into the exponent (0x7BFF + 1 lands exactly on Inf).
  function automatic logic [16:0] pack_lane(input logic [31:0] x);
    logic              s;
    logic [7:0]        e;
    logic [22:0]       f;
    logic signed [8:0] he;
    logic              inc;
    logic [15:0]       half;
    s    = x[31];
    e    = x[30:23];
    f    = x[22:0];
    he   = $signed({1'b0, e}) - 9'sd112;
    inc  = 1'b0;
    half = 16'h0000;
    if (e == 8'hFF)
      half = {s, 5'h1F, (f == 23'd0) ? 10'h000 : 10'h200};
    else if (he >= 9'sd31)
      half = {s, 5'h1F, 10'h000};
    else if (he <= 9'sd0)
      half = {s, 15'h0000};
    else begin
      half = {s, he[4:0], f[22:13]};
      inc  = RNE_EN & f[12] & ((|f[11:0]) | f[13]);
    end
    return {inc, half};
  endfunction

  function automatic logic [31:0] unpack_lane(input logic [15:0] h);
    logic [31:0] r;
    if (h[14:10] == 5'd0)
      r = {h[15], 31'h0};
    else if (h[14:10] == 5'h1F)
      r = {h[15], 8'hFF, h[9:0], 13'h0};
    else
      r = {h[15], {3'b000, h[14:10]} + 8'd112, h[9:0], 13'h0};
    return r;
  endfunction

  logic [16:0] w_lo;
  logic [16:0] w_hi;
  logic [31:0] w_s1_word;
  logic [1:0]  w_s1_inc;
  logic [31:0] w_s2_word;

  logic        r_s1_valid;
  logic [31:0] r_s1_word;
  logic [1:0]  r_s1_inc;
  logic        r_s2_valid;
  logic [31:0] r_s2_word;

  // S1: field split, rebias and range classification.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_lo      = pack_lane(iValRs);
    w_hi      = pack_lane(iValRt);
    w_s1_word = 32'h0;
    w_s1_inc  = 2'b00;
    case (op_e'(iOp))
      OP_PACK: begin
        w_s1_word = {w_hi[15:0], w_lo[15:0]};
        w_s1_inc  = {w_hi[16], w_lo[16]};
      end
      OP_UNP_LO: w_s1_word = unpack_lane(iValRs[15:0]);
      OP_UNP_HI: w_s1_word = unpack_lane(iValRs[31:16]);
      default:   w_s1_word = 32'h0;
    endcase
  end

  // S2: rounding increment; a lane only increments when its prelim value is below 0x7C00.
  assign w_s2_word = {r_s1_word[31:16] + {15'h0, r_s1_inc[1]},
                      r_s1_word[15:0]  + {15'h0, r_s1_inc[0]}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= 32'h0;
      r_s1_inc   <= 2'b00;
      r_s2_valid <= 1'b0;
      r_s2_word  <= 32'h0;
      oValid     <= 1'b0;
      oValRn     <= 32'h0;
    end else if (!iHold) begin
      // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
      r_s1_valid <= iValid;
      r_s1_word  <= iValid ? w_s1_word : 32'h0;
      r_s1_inc   <= iValid ? w_s1_inc  : 2'b00;
      r_s2_valid <= r_s1_valid;
      r_s2_word  <= r_s1_valid ? w_s2_word : 32'h0;
      oValid     <= r_s2_valid;
      oValRn     <= r_s2_valid ? r_s2_word : 32'h0;
    end
  end

endmodule
